// File: rtl/seq_multiplier_hs_if.sv
// Request/result bundle for the sequential multiplier: operands and controls toward the
// multiplier, status and result back to the requester.
interface seq_multiplier_hs_if #(
    parameter int unsigned SIZE = 32
);
    localparam int unsigned CNT_W = $clog2(SIZE) + 1;

    logic                iStart;
    logic                iSigned;
    logic                iAbort;
    logic [SIZE-1:0]     iData_A;
    logic [SIZE-1:0]     iData_B;
    logic                oReady;
    logic                oDone;
    logic [2*SIZE-1:0]   oProduct;
    logic [CNT_W-1:0]    oCycles;

    modport master (
        output iStart, iSigned, iAbort, iData_A, iData_B,
        input  oReady, oDone, oProduct, oCycles
    );

    modport slave (
        input  iStart, iSigned, iAbort, iData_A, iData_B,
        output oReady, oDone, oProduct, oCycles
    );
endinterface

// File: rtl/seq_multiplier_hs.sv
// Shift-add multiplier on operand magnitudes, one bit of the multiplier per cycle, with the
// sign reapplied to the final product; optional early exit once the multiplier runs out.
module seq_multiplier_hs #(
    parameter int unsigned SIZE       = 32,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input logic                Clock,
    input logic                iReset_n,
    seq_multiplier_hs_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SIZE) + 1;
    localparam int unsigned PW    = 2 * SIZE;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    reg_a_q, reg_a_d;
    logic [SIZE-1:0]  reg_b_q, reg_b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic [SIZE-1:0]  mag_a, mag_b;
    logic [PW-1:0]    acc_sum;
    logic [SIZE-1:0]  b_shift;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_iter;

    // -2^(SIZE-1) negates to itself, which is already the correct unsigned magnitude.
    always_comb begin
        mag_a = bus.iData_A;
        mag_b = bus.iData_B;
        if (bus.iSigned && bus.iData_A[SIZE-1]) begin
            mag_a = -bus.iData_A;
        end
        if (bus.iSigned && bus.iData_B[SIZE-1]) begin
            mag_b = -bus.iData_B;
        end
    end

    assign acc_sum   = acc_q + (reg_b_q[0] ? reg_a_q : '0);
    assign b_shift   = reg_b_q >> 1;
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_iter = (cnt_inc == CNT_W'(SIZE)) || (EARLY_EXIT && (b_shift == '0));

    always_comb begin
        state_d   = state_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        cycles_d  = cycles_q;

        unique case (state_q)
            StIdle: begin
                // Start takes priority over a simultaneous abort here.
                if (bus.iStart) begin
                    state_d = StBusy;
                    neg_d   = bus.iSigned & (bus.iData_A[SIZE-1] ^ bus.iData_B[SIZE-1]);
                    reg_a_d = {{SIZE{1'b0}}, mag_a};
                    reg_b_d = mag_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (bus.iAbort) begin
                    state_d = StIdle;
                end else begin
                    acc_d   = acc_sum;
                    reg_a_d = reg_a_q << 1;
                    reg_b_d = b_shift;
                    cnt_d   = cnt_inc;
                    if (last_iter) begin
                        state_d   = StDone;
                        product_d = neg_q ? -acc_sum : acc_sum;
                        cycles_d  = cnt_inc;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= StIdle;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            cycles_q  <= cycles_d;
        end
    end

    assign bus.oReady   = (state_q == StIdle);
    assign bus.oDone    = (state_q == StDone);
    assign bus.oProduct = product_q;
    assign bus.oCycles  = cycles_q;
endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Bench for seq_multiplier_hs: dut0 runs full-length iterations, dut1 exits early; both are
// checked every cycle against a timeline model built from integer multiplication.
module tb_seq_multiplier_hs;
    localparam int SZ = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_hs_if #(.SIZE(SZ)) bus0 ();
    seq_multiplier_hs_if #(.SIZE(SZ)) bus1 ();

    seq_multiplier_hs #(.SIZE(SZ), .EARLY_EXIT(1'b0)) dut0 (
        .Clock(clk), .iReset_n(rst_n), .bus(bus0)
    );
    seq_multiplier_hs #(.SIZE(SZ), .EARLY_EXIT(1'b1)) dut1 (
        .Clock(clk), .iReset_n(rst_n), .bus(bus1)
    );

    logic        start_r[2];
    logic        sgn_r[2];
    logic        abort_r[2];
    logic [7:0]  a_r[2];
    logic [7:0]  b_r[2];
    logic        ready_w[2];
    logic        done_w[2];
    logic [15:0] prod_w[2];
    logic [3:0]  cyc_w[2];

    assign bus0.iStart = start_r[0];
    assign bus0.iSigned = sgn_r[0];
    assign bus0.iAbort = abort_r[0];
    assign bus0.iData_A = a_r[0];
    assign bus0.iData_B = b_r[0];
    assign bus1.iStart = start_r[1];
    assign bus1.iSigned = sgn_r[1];
    assign bus1.iAbort = abort_r[1];
    assign bus1.iData_A = a_r[1];
    assign bus1.iData_B = b_r[1];
    assign ready_w[0] = bus0.oReady;
    assign done_w[0] = bus0.oDone;
    assign prod_w[0] = bus0.oProduct;
    assign cyc_w[0] = bus0.oCycles;
    assign ready_w[1] = bus1.oReady;
    assign done_w[1] = bus1.oDone;
    assign prod_w[1] = bus1.oProduct;
    assign cyc_w[1] = bus1.oCycles;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input bit s);
        int va;
        int vb;
        int p;
        if (s) begin
            va = int'($signed(a));
            vb = int'($signed(b));
        end else begin
            va = int'(a);
            vb = int'(b);
        end
        p = va * vb;
        return p[15:0];
    endfunction

    function automatic int ref_iters(input logic [7:0] b, input bit s, input bit ee);
        int vb;
        int n;
        if (!ee) return SZ;
        if (s) vb = int'($signed(b));
        else   vb = int'(b);
        if (vb < 0) vb = -vb;
        n = 1;
        for (int i = 0; i < SZ; i++) begin
            if (vb[i]) n = i + 1;
        end
        return n;
    endfunction

    // Model: 0 = idle, 1 = busy, 2 = done
    int          m_phase[2];
    int          m_left[2];
    int          m_pcyc[2];
    logic [15:0] m_pprod[2];
    logic [15:0] m_prod[2];
    logic [3:0]  m_cyc[2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_phase[d] <= 0;
                m_left[d]  <= 0;
                m_prod[d]  <= '0;
                m_cyc[d]   <= '0;
            end else begin
                case (m_phase[d])
                    0: if (start_r[d]) begin
                        m_phase[d] <= 1;
                        m_left[d]  <= ref_iters(b_r[d], sgn_r[d], d == 1);
                        m_pcyc[d]  <= ref_iters(b_r[d], sgn_r[d], d == 1);
                        m_pprod[d] <= ref_prod(a_r[d], b_r[d], sgn_r[d]);
                    end
                    1: if (abort_r[d]) begin
                        m_phase[d] <= 0;
                    end else if (m_left[d] == 1) begin
                        m_phase[d] <= 2;
                        m_prod[d]  <= m_pprod[d];
                        m_cyc[d]   <= 4'(m_pcyc[d]);
                    end else begin
                        m_left[d] <= m_left[d] - 1;
                    end
                    default: m_phase[d] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d ready", d), 32'(ready_w[d]), 32'(m_phase[d] == 0));
            chk($sformatf("dut%0d done", d), 32'(done_w[d]), 32'(m_phase[d] == 2));
            chk($sformatf("dut%0d product", d), 32'(prod_w[d]), 32'(m_prod[d]));
            chk($sformatf("dut%0d cycles", d), 32'(cyc_w[d]), 32'(m_cyc[d]));
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        @(negedge clk);
        while (!ready_w[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk($sformatf("dut%0d ready timeout", d), 32'(0), 32'(1));
    endtask

    task automatic op(input int d, input logic [7:0] a, input logic [7:0] b, input bit s,
                      input bit ab, input logic [15:0] ep, input logic [3:0] ec,
                      input int elat, input string nm);
        int lat = 0;
        wait_ready(d);
        start_r[d] = 1'b1;
        abort_r[d] = ab;
        sgn_r[d]   = s;
        a_r[d]     = a;
        b_r[d]     = b;
        @(posedge clk);
        @(negedge clk);
        start_r[d] = 1'b0;
        abort_r[d] = 1'b0;
        while (!done_w[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " product"}, 32'(prod_w[d]), 32'(ep));
        chk({nm, " cycles"}, 32'(cyc_w[d]), 32'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int last;
        int ndone;
        for (int d = 0; d < 2; d++) begin
            start_r[d] = 1'b0;
            sgn_r[d]   = 1'b0;
            abort_r[d] = 1'b0;
            a_r[d]     = '0;
            b_r[d]     = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ready%0d", d), 32'(ready_w[d]), 32'(1));
            chk($sformatf("reset done%0d", d), 32'(done_w[d]), 32'(0));
            chk($sformatf("reset product%0d", d), 32'(prod_w[d]), 32'(0));
            chk($sformatf("reset cycles%0d", d), 32'(cyc_w[d]), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        op(0, 8'd200, 8'd150, 1'b0, 1'b0, 16'h7530, 4'd8, 8, "200x150");
        op(0, 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 4'd8, 8, "s -128x-128");
        op(0, 8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 4'd8, 8, "s -3x5");
        op(0, 8'h80, 8'h7F, 1'b0, 1'b0, 16'h3F80, 4'd8, 8, "128x127");

        op(1, 8'd7, 8'd3, 1'b0, 1'b0, 16'd21, 4'd2, 2, "ee 7x3");
        op(1, 8'd9, 8'd0, 1'b0, 1'b0, 16'd0, 4'd1, 1, "ee 9x0");
        op(1, 8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 4'd3, 3, "ee s -3x5");
        op(1, 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 4'd8, 8, "ee s -128x-128");

        // Abort in the third BUSY cycle keeps the previous result.
        op(0, 8'd4, 8'd4, 1'b0, 1'b0, 16'h0010, 4'd8, 8, "4x4");
        wait_ready(0);
        start_r[0] = 1'b1;
        a_r[0] = 8'd5;
        b_r[0] = 8'd6;
        @(posedge clk);
        @(negedge clk);
        start_r[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort_r[0] = 1'b1;
        @(negedge clk);
        abort_r[0] = 1'b0;
        chk("abort ready", 32'(ready_w[0]), 32'(1));
        chk("abort done", 32'(done_w[0]), 32'(0));
        chk("abort product held", 32'(prod_w[0]), 32'(16'h0010));

        op(0, 8'd11, 8'd13, 1'b0, 1'b1, 16'd143, 4'd8, 8, "start+abort 11x13");

        // Start held high with operands changing every cycle.
        wait_ready(0);
        last = -1;
        ndone = 0;
        start_r[0] = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a_r[0] = 8'(i * 37 + 11);
            b_r[0] = 8'(i * 53 + 5);
            sgn_r[0] = i[0];
            @(negedge clk);
            if (done_w[0]) begin
                if (last >= 0) chk("b2b spacing", 32'(i - last), 32'(SZ + 2));
                last = i;
                ndone++;
            end
        end
        start_r[0] = 1'b0;
        sgn_r[0] = 1'b0;
        chk("b2b result count", 32'(ndone), 32'(4));

        // Asynchronous reset between clock edges mid-operation.
        wait_ready(0);
        start_r[0] = 1'b1;
        a_r[0] = 8'h33;
        b_r[0] = 8'h44;
        @(posedge clk);
        @(negedge clk);
        start_r[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset ready", 32'(ready_w[0]), 32'(1));
        chk("midreset done", 32'(done_w[0]), 32'(0));
        chk("midreset product", 32'(prod_w[0]), 32'(0));
        chk("midreset cycles", 32'(cyc_w[0]), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        op(0, 8'd12, 8'd12, 1'b0, 1'b0, 16'd144, 4'd8, 8, "post-reset 12x12");
        op(1, 8'd12, 8'd12, 1'b0, 1'b0, 16'd144, 4'd4, 4, "ee 12x12");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_multiplier_hs.md
Name: seq_multiplier_hs

Overview:
Parametrised sequential shift-add multiplier with a start/ready/done handshake, an internal iteration counter and a controlling FSM. It supports unsigned and two's-complement signed operands, selected per operation. Optional early termination stops iterating once the remaining multiplier bits are zero. It sits between a register-file/bus master and downstream logic, one multiplication in flight at a time.

Parameters:
SIZE, 32, operand width in bits; product is 2*SIZE bits (SIZE >= 2)
EARLY_EXIT, 0, 1 = finish as soon as shifted multiplier is zero; 0 = always SIZE iterations
CNT_W (localparam), $clog2(SIZE)+1, width of the iteration counter and oCycles

Ports:
Clock  input  1  rising-edge clock; the block's only clock
iReset_n  input  1  asynchronous, active-low reset
iStart  input  1  request a multiplication; accepted only when oReady=1
iSigned  input  1  sampled with iStart: 1 = operands two's-complement, 0 = unsigned
iAbort  input  1  synchronous abort of an operation in progress
iData_A  input  SIZE  multiplicand, sampled on the accept edge
iData_B  input  SIZE  multiplier, sampled on the accept edge
oReady  output  1  block idle, will accept iStart
oDone  output  1  one-cycle pulse: oProduct/oCycles hold a new result
oProduct  output  2*SIZE  last completed product; held until next completion
oCycles  output  CNT_W  number of BUSY iterations used by the last completed product

Behaviour:
- Reset (iReset_n=0, async): state=IDLE, oReady=1, oDone=0, oProduct=0, oCycles=0, internal registers cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: oReady=1. On edge with iStart=1 -> BUSY; latch sign flag neg = iSigned & (A[SIZE-1]^B[SIZE-1]); latch magnitudes (|A|, |B| when iSigned, raw otherwise) into reg_A (2*SIZE, zero-extended) and reg_B (SIZE); accumulator=0; counter=0.
- Magnitude of -2^(SIZE-1) is 2^(SIZE-1), representable unsigned in SIZE bits; no special case.
- BUSY: oReady=0. Each edge: acc += reg_B[0] ? reg_A : 0; reg_A <<= 1; reg_B >>= 1; counter++.
- Exit from BUSY on the edge where counter reaches SIZE (SIZE-th iteration), or, if EARLY_EXIT=1, on the first iteration edge where the shifted reg_B is zero. Minimum one BUSY iteration, including B=0.
- On that exit edge: oProduct <= neg ? -(final acc) : final acc (2*SIZE-bit two's complement); oCycles <= iterations performed; oDone <= 1; state -> DONE.
- Latency: start accepted at edge k -> oDone high in the cycle after edge k+N, where N = SIZE (EARLY_EXIT=0) or 1 + index of the highest set bit of |B| (EARLY_EXIT=1, |B|!=0), 1 when |B|=0.
- DONE: lasts exactly one cycle, oDone=1, oReady=0; next edge -> IDLE, oDone=0. Back-to-back: iStart may be accepted the cycle after DONE.
- iStart while oReady=0: ignored, no queueing.
- iAbort=1 in BUSY: next edge -> IDLE, oDone stays 0, oProduct/oCycles unchanged. iAbort in IDLE/DONE: no effect. iAbort and iStart in the same IDLE cycle: start wins.
- Async reset mid-operation: immediate return to reset values; in-flight result discarded.
- No overflow is possible: product always fits 2*SIZE bits for both modes.

Test Plan:
- SIZE=8, EARLY_EXIT=0, iSigned=0, A=200, B=150 -> oDone 8 cycles after accept edge, oProduct=0x7530, oCycles=8.
- SIZE=8, iSigned=1, A=0x80, B=0x80 (-128*-128) -> oProduct=0x4000; A=0xFD, B=0x05 (-3*5) -> oProduct=0xFFF1; A=0x80, B=0x7F (iSigned=0) -> 0x3F80.
- SIZE=8, EARLY_EXIT=1, A=7, B=3 -> oProduct=21, oCycles=2, oDone 2 cycles after accept; A=9, B=0 -> oProduct=0, oCycles=1.
- Handshake: iStart held high continuously with changing operands -> only operands sampled on oReady=1 edges used; iStart during BUSY ignored; consecutive results one per SIZE+2 cycles.
- Abort: start A=5,B=6 after prior result 0x0010, iAbort at 3rd BUSY cycle -> no oDone, oProduct stays 0x0010, oReady=1 next cycle; iAbort+iStart together in IDLE -> operation starts.
- Reset: assert iReset_n=0 mid-BUSY (between edges) -> outputs immediately 0/oReady=1; release, new op 12*12 -> 144 with full latency.
